// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage types and constants
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int          OCC_W       = 2;
  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - {valid, instr, pc} holding register with clear and load
module pipe_payload_reg
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 22,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEFAULT_NOP),
  parameter logic [PC_W-1:0]    RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic               i_valid,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;

  // Clear wins over load so a flush always leaves the slot in its reset image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= RESET_PC;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= RESET_PC;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF/ID stage with valid/ready handshake and 2-entry skid buffer
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 22,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEFAULT_NOP),
  parameter logic [PC_W-1:0]    RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               hlt,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [OCC_W-1:0]   occ
);

  pipe_state_e        r_state;
  pipe_state_e        w_next_state;

  logic               w_main_valid, w_skid_valid;
  logic [INSTR_W-1:0] w_main_instr, w_skid_instr;
  logic [PC_W-1:0]    w_main_pc, w_skid_pc;

  logic               w_in_fire, w_out_fire, w_illegal, w_clr;
  logic               w_main_load, w_main_d_valid;
  logic [INSTR_W-1:0] w_main_d_instr;
  logic [PC_W-1:0]    w_main_d_pc;
  logic               w_skid_load, w_skid_d_valid;
  logic [INSTR_W-1:0] w_skid_d_instr;
  logic [PC_W-1:0]    w_skid_d_pc;

  // in_ready looks only at held state and hlt/flush, never at out_ready.
  assign in_ready   = !w_skid_valid && !hlt && !flush;
  assign out_valid  = w_main_valid && !hlt && !flush;
  assign out_instr  = out_valid ? w_main_instr : NOP_INSTR;
  assign out_pc     = w_main_pc;
  assign occ        = {1'b0, w_main_valid} + {1'b0, w_skid_valid};
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_illegal  = w_skid_valid && !w_main_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (flush || w_illegal) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) w_next_state = ST_MAIN;
        ST_MAIN: begin
          if (w_in_fire && !w_out_fire)      w_next_state = ST_SKID;
          else if (!w_in_fire && w_out_fire) w_next_state = ST_EMPTY;
        end
        ST_SKID:  if (w_out_fire) w_next_state = ST_MAIN;
        default:  w_next_state = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_clr          = flush || w_illegal;
    w_main_load    = 1'b0;
    w_main_d_valid = 1'b1;
    w_main_d_instr = in_instr;
    w_main_d_pc    = in_pc;
    w_skid_load    = 1'b0;
    w_skid_d_valid = 1'b1;
    w_skid_d_instr = in_instr;
    w_skid_d_pc    = in_pc;
    case (r_state)
      ST_EMPTY: w_main_load = w_in_fire;
      ST_MAIN: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          w_skid_load = 1'b1;
        end else if (w_out_fire) begin
          w_main_load    = 1'b1;
          w_main_d_valid = 1'b0;
          w_main_d_instr = NOP_INSTR;
          w_main_d_pc    = w_main_pc;
        end
      end
      ST_SKID: begin
        if (w_out_fire) begin
          w_main_load    = 1'b1;
          w_main_d_instr = w_skid_instr;
          w_main_d_pc    = w_skid_pc;
          w_skid_load    = 1'b1;
          w_skid_d_valid = 1'b0;
          w_skid_d_instr = w_skid_instr;
          w_skid_d_pc    = w_skid_pc;
        end
      end
      default: w_clr = 1'b1;
    endcase
  end

  pipe_payload_reg #(
    .INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP_INSTR), .RESET_PC(RESET_PC)
  ) u_main (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_load(w_main_load),
    .i_valid(w_main_d_valid), .i_instr(w_main_d_instr), .i_pc(w_main_d_pc),
    .o_valid(w_main_valid), .o_instr(w_main_instr), .o_pc(w_main_pc)
  );

  pipe_payload_reg #(
    .INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP_INSTR), .RESET_PC(RESET_PC)
  ) u_skid (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_load(w_skid_load),
    .i_valid(w_skid_d_valid), .i_instr(w_skid_d_instr), .i_pc(w_skid_d_pc),
    .o_valid(w_skid_valid), .o_instr(w_skid_instr), .o_pc(w_skid_pc)
  );

  a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst) !w_illegal);

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - directed self-checking bench for if_id_skid_stage
module tb_if_id_skid_stage;

  localparam int          INSTR_W = 32;
  localparam int          PC_W    = 22;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [21:0] RPC     = 22'h0003F0;

  logic               clk = 1'b0;
  logic               rst, flush, hlt, in_valid, in_ready, out_valid, out_ready;
  logic [INSTR_W-1:0] in_instr, out_instr;
  logic [PC_W-1:0]    in_pc, out_pc;
  logic [1:0]         occ;

  int checks = 0;
  int errors = 0;

  if_id_skid_stage #(
    .INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .hlt(hlt),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] ins, input logic [21:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hlt = 1'b0; out_ready = 1'b0;
    offer(1'b0, 32'h0, 22'h0);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'(NOP));
    chk("rst_out_pc", 64'(out_pc), 64'(RPC));
    step(); step();
    rst = 1'b0;

    // Streaming: each word appears exactly one cycle after it is offered.
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      offer(1'b1, 32'h1111_1111 * (k + 1), 22'h100 + 22'(k));
      #1;
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (k > 0) begin
        chk("stream_out_valid", 64'(out_valid), 64'd1);
        chk("stream_out_instr", 64'(out_instr), 64'(32'h1111_1111 * k));
        chk("stream_out_pc", 64'(out_pc), 64'(22'h100 + 22'(k - 1)));
        chk("stream_occ", 64'(occ), 64'd1);
      end
      step();
    end
    offer(1'b0, 32'h0, 22'h0);
    #1;
    chk("stream_last_instr", 64'(out_instr), 64'h5555_5555);
    chk("stream_last_pc", 64'(out_pc), 64'h104);
    step();
    chk("stream_drain_occ", 64'(occ), 64'd0);
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_drain_instr", 64'(out_instr), 64'(NOP));

    // Back-pressure: A held in main, B lands in skid, then both drain in order.
    out_ready = 1'b0;
    offer(1'b1, 32'hAAAA_0000, 22'h200);
    step();
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    chk("bp_a_instr", 64'(out_instr), 64'hAAAA_0000);
    chk("bp_occ1", 64'(occ), 64'd1);
    chk("bp_in_ready1", 64'(in_ready), 64'd1);
    offer(1'b1, 32'hBBBB_0000, 22'h201);
    step();
    offer(1'b0, 32'h0, 22'h0);
    #1;
    chk("bp_occ2", 64'(occ), 64'd2);
    chk("bp_in_ready2", 64'(in_ready), 64'd0);
    chk("bp_head_still_a", 64'(out_instr), 64'hAAAA_0000);
    out_ready = 1'b1;
    #1;
    chk("bp_out_a_pc", 64'(out_pc), 64'h200);
    step();
    chk("bp_out_b_instr", 64'(out_instr), 64'hBBBB_0000);
    chk("bp_out_b_pc", 64'(out_pc), 64'h201);
    chk("bp_occ_after_a", 64'(occ), 64'd1);
    step();
    chk("bp_occ_after_b", 64'(occ), 64'd0);
    chk("bp_empty_valid", 64'(out_valid), 64'd0);

    // Flush with two entries held; the word offered during flush is dropped.
    out_ready = 1'b0;
    offer(1'b1, 32'hA1A1_0001, 22'h210);
    step();
    offer(1'b1, 32'hB2B2_0002, 22'h211);
    step();
    chk("fl_pre_occ", 64'(occ), 64'd2);
    flush = 1'b1;
    offer(1'b1, 32'hC3C3_0003, 22'h212);
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd0);
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_instr_gated", 64'(out_instr), 64'(NOP));
    step();
    flush = 1'b0;
    offer(1'b0, 32'h0, 22'h0);
    #1;
    chk("fl_occ", 64'(occ), 64'd0);
    chk("fl_out_instr", 64'(out_instr), 64'(NOP));
    chk("fl_out_pc", 64'(out_pc), 64'(RPC));
    chk("fl_out_valid_after", 64'(out_valid), 64'd0);

    // Halt with one entry: frozen for three cycles, then delivered exactly once.
    out_ready = 1'b1;
    offer(1'b1, 32'hD00D_0004, 22'h300);
    step();
    offer(1'b0, 32'h0, 22'h0);
    hlt = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hlt_out_valid", 64'(out_valid), 64'd0);
      chk("hlt_in_ready", 64'(in_ready), 64'd0);
      chk("hlt_occ", 64'(occ), 64'd1);
      step();
    end
    hlt = 1'b0;
    #1;
    chk("hlt_rel_valid", 64'(out_valid), 64'd1);
    chk("hlt_rel_instr", 64'(out_instr), 64'hD00D_0004);
    chk("hlt_rel_pc", 64'(out_pc), 64'h300);
    step();
    chk("hlt_once_occ", 64'(occ), 64'd0);
    chk("hlt_once_valid", 64'(out_valid), 64'd0);

    // Flush and halt together: flush wins.
    out_ready = 1'b0;
    offer(1'b1, 32'hE0E0_0005, 22'h310);
    step();
    offer(1'b1, 32'hF0F0_0006, 22'h311);
    step();
    offer(1'b0, 32'h0, 22'h0);
    flush = 1'b1;
    hlt   = 1'b1;
    #1;
    chk("flh_in_ready", 64'(in_ready), 64'd0);
    chk("flh_out_valid", 64'(out_valid), 64'd0);
    step();
    flush = 1'b0;
    hlt   = 1'b0;
    #1;
    chk("flh_occ", 64'(occ), 64'd0);
    chk("flh_out_pc", 64'(out_pc), 64'(RPC));

    // Async reset between edges with two entries held.
    offer(1'b1, 32'h6060_0007, 22'h320);
    step();
    offer(1'b1, 32'h7070_0008, 22'h321);
    step();
    offer(1'b0, 32'h0, 22'h0);
    chk("ar_pre_occ", 64'(occ), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_occ", 64'(occ), 64'd0);
    chk("ar_out_instr", 64'(out_instr), 64'(NOP));
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    offer(1'b1, 32'h9090_0009, 22'h400);
    #1;
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_not_yet_valid", 64'(out_valid), 64'd0);
    step();
    offer(1'b0, 32'h0, 22'h0);
    #1;
    chk("ar_first_valid", 64'(out_valid), 64'd1);
    chk("ar_first_instr", 64'(out_instr), 64'h9090_0009);
    chk("ar_first_pc", 64'(out_pc), 64'h400);
    step();
    chk("ar_final_occ", 64'(occ), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
